// File: rtl/tl_ram_responder_if.sv
// TileLink-UL A/D channel bundle between a requester (master) and the RAM responder (slave).
interface tl_ram_responder_if;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [3:0]  a_size;
    logic [3:0]  a_source;
    logic [31:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic        a_corrupt;

    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [3:0]  d_size;
    logic [3:0]  d_source;
    logic        d_sink;
    logic        d_denied;
    logic [63:0] d_data;
    logic        d_corrupt;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
        output d_ready
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
        input  d_ready
    );
endinterface

// File: rtl/tl_ram_responder.sv
// TileLink-UL scratchpad manager: services Get/Put from a 64-bit RAM and
// returns responses through a 2-entry FIFO (1-cycle minimum latency, no bypass).
module tl_ram_responder #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter logic [31:0] BASE       = 32'h1000_0000
) (
    input  logic             clock,
    input  logic             reset,
    tl_ram_responder_if.slave io
);

    localparam int unsigned WORDS  = 1 << DEPTH_LOG2;
    localparam int unsigned IDX_W  = DEPTH_LOG2;
    localparam int unsigned DATA_W = 64;

    localparam logic [2:0] OPC_PUT_FULL    = 3'd0;
    localparam logic [2:0] OPC_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OPC_ARITH       = 3'd2;
    localparam logic [2:0] OPC_LOGIC       = 3'd3;
    localparam logic [2:0] OPC_GET         = 3'd4;
    localparam logic [2:0] OPC_ACK         = 3'd0;
    localparam logic [2:0] OPC_ACK_DATA    = 3'd1;

    typedef struct packed {
        logic [2:0]        opcode;
        logic [3:0]        size;
        logic [3:0]        source;
        logic              denied;
        logic [DATA_W-1:0] data;
        logic              corrupt;
    } resp_t;

    logic [DATA_W-1:0] mem [WORDS];

    logic [31:0]      offset;
    logic             in_range;
    logic             size_bad;
    logic             misaligned;
    logic             addr_bad;
    logic [IDX_W-1:0] idx;
    logic             a_fire;
    logic             d_fire;
    logic             write_en;
    resp_t            resp_c;

    resp_t            fifo_q [2];
    logic             enq_ptr;
    logic             deq_ptr;
    logic             maybe_full;
    logic             ptr_match;
    logic             empty;
    logic             full;
    resp_t            head;

    logic             unused_a_param;
    assign unused_a_param = ^io.a_param;

    // Address decode and legality
    assign offset   = io.a_address - BASE;
    assign in_range = (offset >> (DEPTH_LOG2 + 3)) == 32'd0;
    assign idx      = offset[DEPTH_LOG2+2:3];
    assign size_bad = io.a_size > 4'd3;

    always_comb begin
        misaligned = 1'b0;
        case (io.a_size[1:0])
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = io.a_address[0];
            2'd2:    misaligned = |io.a_address[1:0];
            default: misaligned = |io.a_address[2:0];
        endcase
    end

    assign addr_bad = ~in_range | size_bad | misaligned;

    // Response formed in the accept cycle from the pre-edge RAM contents
    always_comb begin
        resp_c        = '0;
        resp_c.size   = io.a_size;
        resp_c.source = io.a_source;
        case (io.a_opcode)
            OPC_PUT_FULL, OPC_PUT_PARTIAL: begin
                resp_c.opcode = OPC_ACK;
                resp_c.denied = addr_bad;
            end
            OPC_GET: begin
                resp_c.opcode  = OPC_ACK_DATA;
                resp_c.denied  = addr_bad;
                resp_c.corrupt = addr_bad;
                resp_c.data    = addr_bad ? '0 : mem[idx];
            end
            OPC_ARITH, OPC_LOGIC: begin
                resp_c.opcode  = OPC_ACK_DATA;
                resp_c.denied  = 1'b1;
                resp_c.corrupt = 1'b1;
            end
            default: begin
                resp_c.opcode = OPC_ACK;
                resp_c.denied = 1'b1;
            end
        endcase
    end

    assign a_fire   = io.a_valid & io.a_ready;
    assign d_fire   = io.d_valid & io.d_ready;
    assign write_en = a_fire & ~addr_bad & ~io.a_corrupt &
                      ((io.a_opcode == OPC_PUT_FULL) | (io.a_opcode == OPC_PUT_PARTIAL));

    // Byte-lane RAM write; held off while reset is asserted
    always_ff @(posedge clock) begin
        if (reset && write_en) begin
            for (int i = 0; i < 8; i++) begin
                if (io.a_mask[i]) begin
                    mem[idx][8*i +: 8] <= io.a_data[8*i +: 8];
                end
            end
        end
    end

    // Response FIFO with wrapping 1-bit pointers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enq_ptr    <= 1'b0;
            deq_ptr    <= 1'b0;
            maybe_full <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
        end else begin
            if (a_fire) begin
                fifo_q[enq_ptr] <= resp_c;
                enq_ptr         <= ~enq_ptr;
            end
            if (d_fire) begin
                deq_ptr <= ~deq_ptr;
            end
            if (a_fire != d_fire) begin
                maybe_full <= a_fire;
            end
        end
    end

    assign ptr_match = enq_ptr == deq_ptr;
    assign empty     = ptr_match & ~maybe_full;
    assign full      = ptr_match & maybe_full;
    assign head      = fifo_q[deq_ptr];

    assign io.a_ready   = ~full;
    assign io.d_valid   = ~empty;
    assign io.d_opcode  = head.opcode;
    assign io.d_param   = 2'b00;
    assign io.d_size    = head.size;
    assign io.d_source  = head.source;
    assign io.d_sink    = 1'b0;
    assign io.d_denied  = head.denied;
    assign io.d_data    = head.data;
    assign io.d_corrupt = head.corrupt;

endmodule
